field_cfg_loader: RTL
=====================

// Module: field_cfg_loader
// PURPOSE
//  Responder side of the field-config load handshake; the initiator is the loader controller.
//  - Accepts a one-cycle go pulse plus a load_cfg_req_t.
//  - Holds o_is_loading high for the whole load.
//  - Streams one field row per cycle from the config ROM into the field memory write port.
//  - MEM_INIT clears the field to zeros without reading the ROM.
// PARAMETERS
//  FIELD_W     defs::FIELD_W  cells per row = width of one field-memory word
//  FIELD_H     defs::FIELD_H  rows in the field; power of two, >= 2
//  CFG1_BASE   0              ROM row address of row 0 of CFG_1
//  CFG2_BASE   FIELD_H        ROM row address of row 0 of CFG_2
//  ROM_ADDR_W  $clog2(2*FIELD_H)  config ROM address width
// PORTS
//  clk               in   1           system clock, rising edge
//  rst_n             in   1           asynchronous, active-low reset
//  i_go              in   1           start pulse from the controller
//  i_load_cfg_req    in   load_cfg_req_t  request, sampled only together with i_go
//  o_is_loading      out  1           busy; high from the cycle after go until the last write retires
//  o_rom_en          out  1           config ROM read enable
//  o_rom_addr        out  ROM_ADDR_W  config ROM row address (synchronous ROM, 1-cycle read latency)
//  i_rom_data        in   FIELD_W     ROM row data, valid the cycle after o_rom_en
//  o_wr_en           out  1           field memory row write enable
//  o_wr_addr         out  $clog2(FIELD_H)  field row being written
//  o_wr_data         out  FIELD_W     row data written to field memory
// BEHAVIOUR
//  Reset: every output is 0 (o_is_loading, o_rom_en, o_rom_addr, o_wr_*). FSM goes to IDLE.
//  FSM states: IDLE, LOAD, DRAIN.
//  IDLE
//   - i_go=1 with req in {CFG_1, CFG_2, MEM_INIT}: latch req, rd_row<=0, ->LOAD, o_is_loading<=1.
//     These updates happen on the same edge that samples i_go (registered output).
//   - i_go=1 with NO_REQ: ignored, stay IDLE.
//  LOAD (one ROM read per cycle)
//   - o_rom_en=1 and o_rom_addr = base + rd_row; base = CFG1_BASE or CFG2_BASE.
//   - MEM_INIT: o_rom_en=0 and o_rom_addr=0 throughout.
//   - rd_row increments each cycle. After issuing row FIELD_H-1, ->DRAIN.
//  Read pipeline: 1-stage valid/row pipe (rd_vld, wr_row) aligned to the ROM latency.
//   - o_wr_en = rd_vld; o_wr_addr = wr_row.
//   - o_wr_data = i_rom_data for CFG_1/CFG_2; all-zero for MEM_INIT.
//  DRAIN: the final write (row FIELD_H-1) occurs this cycle; ->IDLE and o_is_loading<=0.
//  Timing, with cycle 0 = the go cycle:
//   - o_is_loading high in cycles 1..FIELD_H+1.
//   - Writes to rows 0..FIELD_H-1 occur in cycles 2..FIELD_H+1, exactly once each, ascending.
//   - o_is_loading low from cycle FIELD_H+2.
//  Handshake rules:
//   - o_is_loading is high in the cycle after go; the controller polls it then.
//   - i_go while not IDLE is ignored; the latched req is unchanged.
//   - Back-to-back loads: a go in the first IDLE cycle is accepted.
//  Boundary conditions:
//   - rd_row width $clog2(FIELD_H); the terminal row is detected by compare, never by wrap.
//   - ROM address computed at ROM_ADDR_W; base + rd_row must not overflow (assert in sim).
//   - rst_n low mid-load: outputs clear asynchronously and the write stream stops; no partial-row write.
//     The controller re-issues MEM_INIT after reset.
//  Unknown or out-of-enum req values are treated as NO_REQ.
// STRUCTURE
//  defs package:
//   - load_cfg_req_t (NO_REQ, CFG_1, CFG_2, MEM_INIT) and FIELD_W/FIELD_H.
//   - New: CFG1_BASE_ROW and CFG2_BASE_ROW constants, shared with the ROM init file generator.
//  Local typedef: state_t {IDLE, LOAD, DRAIN}.
//  No sub-module: FSM, row counter and 1-stage valid pipe stay in this file.
//  The config ROM lives outside this block, at top level.
// TESTING (FIELD_W=32, FIELD_H=32; ROM model: row a holds 32'hA5000000|a)
//  1. Release rst_n, go+MEM_INIT in cycle 0:
//     -> o_is_loading high cycles 1..33; 32 writes rows 0..31, data 0; o_rom_en never 1.
//  2. go+CFG_1:
//     -> o_rom_addr 0..31 in cycles 1..32; write row r carries 32'hA5000000|r; is_loading low in cycle 34.
//  3. go+CFG_2:
//     -> o_rom_addr 32..63; write row r carries 32'hA5000000|(32+r).
//  4. go+CFG_2 mid-CFG_1 load (cycle 10), and go+NO_REQ while IDLE:
//     -> both ignored; CFG_1 data completes unchanged; NO_REQ leaves o_is_loading 0.
//  5. rst_n low in cycle 12 of a CFG_1 load:
//     -> all outputs 0 immediately; no writes after reset; next go+MEM_INIT completes normally.
//  6. go+CFG_1 in the first cycle o_is_loading is 0 after a load:
//     -> accepted; is_loading high the next cycle; all 32 rows rewritten.

Source files
------------

// File: rtl/field_cfg_loader_pkg.sv
// Shared field geometry, config ROM layout and the load request encoding.
// The ROM row bases are also consumed by the ROM init file generator.
package field_cfg_loader_pkg;

  localparam int unsigned FIELD_W = 32;
  localparam int unsigned FIELD_H = 32;

  // CFG_1 occupies ROM rows [0, FIELD_H); CFG_2 follows immediately after.
  localparam int unsigned CFG1_BASE_ROW = 0;
  localparam int unsigned CFG2_BASE_ROW = FIELD_H;

  typedef enum logic [1:0] {
    NO_REQ   = 2'd0,
    CFG_1    = 2'd1,
    CFG_2    = 2'd2,
    MEM_INIT = 2'd3
  } load_cfg_req_t;

endpackage

// File: rtl/field_cfg_loader.sv
// Responder for the field-config load handshake: streams FIELD_H rows from the
// config ROM (or zeros for MEM_INIT) into the field memory write port.
module field_cfg_loader
  import field_cfg_loader_pkg::*;
#(
  parameter int unsigned FIELD_W    = field_cfg_loader_pkg::FIELD_W,
  parameter int unsigned FIELD_H    = field_cfg_loader_pkg::FIELD_H,
  parameter int unsigned CFG1_BASE  = field_cfg_loader_pkg::CFG1_BASE_ROW,
  parameter int unsigned CFG2_BASE  = field_cfg_loader_pkg::CFG2_BASE_ROW,
  parameter int unsigned ROM_ADDR_W = $clog2(2 * FIELD_H)
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       i_go,
  input  load_cfg_req_t              i_load_cfg_req,
  output logic                       o_is_loading,
  output logic                       o_rom_en,
  output logic [ROM_ADDR_W-1:0]      o_rom_addr,
  input  logic [FIELD_W-1:0]         i_rom_data,
  output logic                       o_wr_en,
  output logic [$clog2(FIELD_H)-1:0] o_wr_addr,
  output logic [FIELD_W-1:0]         o_wr_data
);

  localparam int unsigned ROW_W = $clog2(FIELD_H);
  localparam int unsigned AW1   = ROM_ADDR_W + 1;

  localparam logic [ROW_W-1:0] LastRow  = ROW_W'(FIELD_H - 1);
  localparam logic [AW1-1:0]   Cfg1Base = AW1'(CFG1_BASE);
  localparam logic [AW1-1:0]   Cfg2Base = AW1'(CFG2_BASE);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t           r_state, w_state_nxt;
  load_cfg_req_t    r_req, w_req_nxt;
  logic [ROW_W-1:0] r_rd_row, w_rd_row_nxt;
  logic [ROW_W-1:0] r_wr_row;
  logic             r_rd_vld;
  logic             r_is_loading;
  logic             w_go_valid;
  logic             w_issue;
  logic             w_from_rom;
  logic [AW1-1:0]   w_base;
  logic [AW1-1:0]   w_rom_addr_wide;

  // Anything outside the three load requests (including X) is treated as NO_REQ.
  always_comb begin
    w_go_valid = 1'b0;
    case (i_load_cfg_req)
      CFG_1, CFG_2, MEM_INIT: w_go_valid = 1'b1;
      default:                w_go_valid = 1'b0;
    endcase
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_req_nxt    = r_req;
    w_rd_row_nxt = r_rd_row;
    w_issue      = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (i_go && w_go_valid) begin
          w_state_nxt  = LOAD;
          w_req_nxt    = i_load_cfg_req;
          w_rd_row_nxt = '0;
        end
      end
      LOAD: begin
        w_issue = 1'b1;
        if (r_rd_row == LastRow) begin
          w_state_nxt = DRAIN;
        end else begin
          w_rd_row_nxt = r_rd_row + 1'b1;
        end
      end
      DRAIN: begin
        w_state_nxt = IDLE;
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= IDLE;
      r_req        <= NO_REQ;
      r_rd_row     <= '0;
      r_wr_row     <= '0;
      r_rd_vld     <= 1'b0;
      r_is_loading <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_req        <= w_req_nxt;
      r_rd_row     <= w_rd_row_nxt;
      r_wr_row     <= r_rd_row;
      r_rd_vld     <= w_issue;
      r_is_loading <= (w_state_nxt != IDLE);
    end
  end

  assign w_from_rom      = (r_req == CFG_1) || (r_req == CFG_2);
  assign w_base          = (r_req == CFG_2) ? Cfg2Base : Cfg1Base;
  // One spare bit so an out-of-range base + row is caught rather than wrapped.
  assign w_rom_addr_wide = w_base + AW1'(r_rd_row);

  assign o_is_loading = r_is_loading;
  assign o_rom_en     = w_issue && w_from_rom;
  assign o_rom_addr   = o_rom_en ? w_rom_addr_wide[ROM_ADDR_W-1:0] : '0;
  assign o_wr_en      = r_rd_vld;
  assign o_wr_addr    = r_rd_vld ? r_wr_row : '0;
  assign o_wr_data    = (r_rd_vld && w_from_rom) ? i_rom_data : '0;

  rom_addr_in_range_a: assert property (
    @(posedge clk) disable iff (!rst_n) o_rom_en |-> !w_rom_addr_wide[ROM_ADDR_W]
  );

endmodule
